// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// The state encoding and the carry majority function live here so the cell and the controller agree.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int SA_MAX_WIDTH = 64;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ci_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             co_out;

    modport master (output start, a_in, b_in, ci_in,
                    input  busy, done, sum_out, co_out);

    modport slave  (input  start, a_in, b_in, ci_in,
                    output busy, done, sum_out, co_out);

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single combinational full-adder cell, time-shared across all operand bits.
module fa_cell
    import serial_add_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = maj3(a, b, ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB-first, one bit per clock.
// Result and carry-out are registered on the last RUN cycle, so they are valid while done is high.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sa_state_t        state_r;
    sa_state_t        state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             co_r;
    logic             busy_r;
    logic             done_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_co_s;

    fa_cell u_fa (
        .a   (a_sh_r[0]),
        .b   (b_sh_r[0]),
        .ci  (carry_r),
        .sum (fa_sum_s),
        .co  (fa_co_s)
    );

    // New sum bit enters at the MSB; written as shifts so WIDTH=1 needs no special case.
    assign acc_next_s = (acc_r >> 1'b1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            co_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_r  <= bus.a_in;
                        b_sh_r  <= bus.b_in;
                        carry_r <= bus.ci_in;
                        acc_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                RUN: begin
                    a_sh_r  <= a_sh_r >> 1'b1;
                    b_sh_r  <= b_sh_r >> 1'b1;
                    acc_r   <= acc_next_s;
                    carry_r <= fa_co_s;
                    cnt_r   <= cnt_r + CW'(1'b1);
                    // Last bit: publish the completed word so it lines up with done.
                    if (cnt_r == LAST_CNT) begin
                        sum_r <= acc_next_s;
                        co_r  <= fa_co_s;
                    end else begin
                        sum_r <= sum_r;
                    end
                end
                DONE:    cnt_r <= cnt_r;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.sum_out = sum_r;
    assign bus.co_out  = co_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl at WIDTH = 1, 8 and 13 against an arithmetic model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int          widths [3] = '{1, 8, 13};
    logic [63:0] prev_sum [3];
    logic        prev_co  [3];

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(1))  if1  ();
    serial_add_ctrl_if #(.WIDTH(8))  if8  ();
    serial_add_ctrl_if #(.WIDTH(13)) if13 ();

    serial_add_ctrl #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(if1));
    serial_add_ctrl #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8));
    serial_add_ctrl #(.WIDTH(13)) u_w13 (.clk(clk), .rst(rst), .bus(if13));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [63:0] a,
                         input logic [63:0] b, input logic ci);
        case (sel)
            0: begin if1.start  = st; if1.a_in  = a[0:0];  if1.b_in  = b[0:0];  if1.ci_in  = ci; end
            1: begin if8.start  = st; if8.a_in  = a[7:0];  if8.b_in  = b[7:0];  if8.ci_in  = ci; end
            default: begin if13.start = st; if13.a_in = a[12:0]; if13.b_in = b[12:0]; if13.ci_in = ci; end
        endcase
    endtask

    task automatic sample(input int sel, output logic bz, output logic dn,
                          output logic [63:0] s, output logic co);
        case (sel)
            0: begin bz = if1.busy;  dn = if1.done;  s = 64'(if1.sum_out);  co = if1.co_out;  end
            1: begin bz = if8.busy;  dn = if8.done;  s = 64'(if8.sum_out);  co = if8.co_out;  end
            default: begin bz = if13.busy; dn = if13.done; s = 64'(if13.sum_out); co = if13.co_out; end
        endcase
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One add: start, optionally scramble inputs during RUN, then check latency, pulse shape and result.
    task automatic do_add(input int sel, input logic [63:0] a_raw, input logic [63:0] b_raw,
                          input logic ci, input bit scramble, input string tag);
        int          w;
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] full;
        logic [63:0] exp_sum;
        logic        exp_co;
        int          busy_cnt;
        int          done_cnt;
        int          done_k;
        bit          hold_bad;
        logic        bz;
        logic        dn;
        logic [63:0] s;
        logic        co;
        logic [63:0] got_s;
        logic        got_co;
        w        = widths[sel];
        mask     = (64'd1 << w) - 64'd1;
        a        = a_raw & mask;
        b        = b_raw & mask;
        full     = {1'b0, a} + {1'b0, b} + 65'(ci);
        exp_sum  = full[63:0] & mask;
        exp_co   = full[w];
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = 0;
        hold_bad = 1'b0;
        got_s    = 64'd0;
        got_co   = 1'b0;
        s        = 64'd0;
        drive(sel, 1'b1, a, b, ci);
        @(posedge clk);
        #1;
        if (scramble) drive(sel, 1'($urandom), rnd64(), rnd64(), 1'($urandom));
        else          drive(sel, 1'b0, a, b, ci);
        for (int k = 1; k <= w + 6; k++) begin
            @(negedge clk);
            sample(sel, bz, dn, s, co);
            if (bz) busy_cnt++;
            if (dn) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k = k;
                    got_s  = s;
                    got_co = co;
                end
            end else if (done_k == 0 && (s !== prev_sum[sel] || co !== prev_co[sel])) begin
                hold_bad = 1'b1;
            end
            if (scramble && k < w + 1) drive(sel, 1'($urandom), rnd64(), rnd64(), 1'($urandom));
            else                       drive(sel, 1'b0, a, b, ci);
            if (done_k != 0 && !bz) break;
        end
        check({tag, ":lat"},   64'(done_k),   64'(w + 1));
        check({tag, ":dones"}, 64'(done_cnt), 64'd1);
        check({tag, ":busy"},  64'(busy_cnt), 64'(w + 1));
        check({tag, ":sum"},   got_s,         exp_sum);
        check({tag, ":co"},    64'(got_co),   64'(exp_co));
        check({tag, ":hold"},  64'(hold_bad), 64'd0);
        check({tag, ":keep"},  s,             exp_sum);
        prev_sum[sel] = exp_sum;
        prev_co[sel]  = exp_co;
    endtask

    initial begin
        logic        bz;
        logic        dn;
        logic [63:0] s;
        logic        co;
        int          dn_seen;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 64'd0, 64'd0, 1'b0);
            prev_sum[i] = 64'd0;
            prev_co[i]  = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample(i, bz, dn, s, co);
            check("rst:busy", 64'(bz), 64'd0);
            check("rst:done", 64'(dn), 64'd0);
            check("rst:sum",  s,       64'd0);
            check("rst:co",   64'(co), 64'd0);
        end

        do_add(1, 64'h00, 64'h00, 1'b0, 1'b0, "zero");
        do_add(1, 64'hFF, 64'h01, 1'b0, 1'b0, "ff_01");
        do_add(1, 64'h7F, 64'h01, 1'b0, 1'b0, "7f_01");
        do_add(1, 64'hA5, 64'h5A, 1'b1, 1'b1, "a5_5a_scr");

        // Abort in the fourth RUN cycle: everything returns to zero and no done follows.
        drive(1, 1'b1, 64'h3C, 64'h0F, 1'b0);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 64'h3C, 64'h0F, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        sample(1, bz, dn, s, co);
        check("abort:busy", 64'(bz), 64'd0);
        check("abort:done", 64'(dn), 64'd0);
        check("abort:sum",  s,       64'd0);
        check("abort:co",   64'(co), 64'd0);
        dn_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sample(1, bz, dn, s, co);
            if (dn) dn_seen++;
        end
        check("abort:nodone", 64'(dn_seen), 64'd0);
        for (int i = 0; i < 3; i++) begin
            prev_sum[i] = 64'd0;
            prev_co[i]  = 1'b0;
        end
        do_add(1, 64'h01, 64'h02, 1'b0, 1'b0, "post_abort");

        do_add(0, 64'd1, 64'd1, 1'b1, 1'b0, "w1_111");
        do_add(0, 64'd0, 64'd1, 1'b0, 1'b1, "w1_010");

        for (int i = 0; i < 1000; i++)
            do_add(1, rnd64(), rnd64(), 1'($urandom), (i % 4) == 0, "rnd8");
        for (int i = 0; i < 1000; i++)
            do_add(2, rnd64(), rnd64(), 1'($urandom), (i % 4) == 1, "rnd13");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder controller that time-shares one full-adder cell over a WIDTH-bit operand pair.
- Sequences the cell LSB-first, one bit per clock, and holds the running carry in a flip-flop.
- Exposes a start/busy/done handshake to the surrounding datapath.
- Trades WIDTH cycles of latency for a single adder cell in area-constrained arithmetic paths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured on an accepted start
- b_in  input  WIDTH  operand B; captured on an accepted start
- ci_in  input  1  carry-in; captured on an accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse; result valid
- sum_out  output  WIDTH  result; held until the next accepted start
- co_out  output  1  final carry-out; held with sum_out

Behaviour:
- Decided interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - state=IDLE; busy=0; done=0; sum_out=0; co_out=0.
  - Operand shift regs, carry reg and bit counter are cleared.
- Reset mid-operation aborts the add. The next cycle is IDLE with all outputs 0. No done pulse is produced for the aborted add.
- States are IDLE, RUN and DONE.
- IDLE:
  - When start=1, capture a_in->a_sh, b_in->b_sh and ci_in->carry, clear the accumulator and set cnt=0. Next state is RUN.
  - When start=0, stay in IDLE.
  - sum_out and co_out keep their last result.
- RUN, each cycle:
  - fa_cell evaluates (a_sh[0], b_sh[0], carry) to give (s, c).
  - acc <= {s, acc[WIDTH-1:1]}, i.e. shift right with the new bit entering the MSB.
  - a_sh and b_sh shift right by 1. carry <= c. cnt <= cnt+1.
  - When cnt==WIDTH-1, the next state is DONE.
- Transition RUN->DONE: sum_out <= final acc (including the last bit) and co_out <= final carry. Both registered, so they are valid in the same cycle that done=1.
- DONE: done=1 and busy=1 for exactly one cycle. Next state is IDLE unconditionally.
- Latency: start accepted at edge N (leaving IDLE) -> done high during cycle N+WIDTH+1 -> IDLE again at N+WIDTH+2. Back-to-back throughput is one add per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored and not queued. The operands in flight are unaffected by changes on a_in, b_in or ci_in.
- sum_out and co_out update only on the RUN->DONE transition. They stay stable through IDLE and through the whole next RUN.
- cnt width is $clog2(WIDTH+1). It never wraps within a run.
- WIDTH=1: RUN lasts exactly 1 cycle.
- Arithmetic is unsigned: {co_out, sum_out} == a_in + b_in + ci_in, with no truncation beyond WIDTH+1 bits.

Decomposition:
- Package serial_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t.
  - localparam SA_MAX_WIDTH = 64.
- Sub-module fa_cell is purely combinational:
  - inputs a, b, ci; outputs sum, co.
  - sum = a^b^ci; co = majority(a, b, ci).
  - Instantiated once.
- The controller holds the FSM, shift registers, carry flip-flop, counter and output registers.

Test Plan:
- Reset, then start with a=0x00, b=0x00, ci=0 -> done pulses exactly 9 cycles after the accepting edge; sum_out=0x00, co_out=0; busy=1 for 9 cycles.
- a=0xFF, b=0x01, ci=0 -> sum_out=0x00, co_out=1. Then a=0x7F, b=0x01, ci=0 -> sum_out=0x80, co_out=0; sum_out holds 0x00 throughout the second RUN.
- a=0xA5, b=0x5A, ci=1 -> sum_out=0x00, co_out=1. Change a_in, b_in and start every cycle during RUN -> result unchanged and exactly one done pulse.
- Start a=0x3C, b=0x0F; assert rst for 1 cycle at RUN cycle 4 -> next cycle IDLE, busy=0, done never pulses, sum_out=0, co_out=0. A new start with a=0x01, b=0x02 then gives 0x03.
- WIDTH=1: a=1, b=1, ci=1 -> done 2 cycles after accept; sum_out=1, co_out=1.
- Random sweep with 1000 vectors at WIDTH=8 and WIDTH=13 -> every result matches a+b+ci. done is always a one-cycle pulse.
